// File: rtl/prefetch_queue.sv
// Instruction prefetch unit: serial word fetch, small word queue, inst/imm registers
// and the architectural PC, which the decoder reads and writes one beat at a time.
module prefetch_queue #(
  parameter int unsigned NSHIFT      = 2,
  parameter int unsigned QUEUE_WORDS = 2,
  parameter int unsigned WORD_BEATS  = 16 / NSHIFT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              fetch_req_o,
  output logic [15:0]       fetch_addr_o,
  input  logic              fetch_ack_i,
  input  logic              fetch_data_valid_i,
  input  logic [NSHIFT-1:0] fetch_data_i,
  input  logic              block_prefetch_i,
  output logic              prefetch_idle_o,
  output logic              inst_valid_o,
  output logic [15:0]       inst_o,
  input  logic              inst_done_i,
  input  logic              load_imm16_i,
  output logic              imm16_loaded_o,
  output logic [15:0]       imm_full_o,
  output logic [NSHIFT-1:0] imm_data_in_o,
  input  logic              next_imm_data_i,
  input  logic              write_pc_i,
  input  logic [NSHIFT-1:0] pc_data_out_i,
  input  logic [2:0]        comp_counter_i,
  output logic [NSHIFT-1:0] pc_data_in_o
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned SR_W   = WORD_W - NSHIFT;
  localparam int unsigned BEAT_W = $clog2(WORD_BEATS);
  localparam int unsigned CNT_W  = $clog2(QUEUE_WORDS + 1);
  localparam int unsigned SH_W   = 5;
  localparam logic [WORD_W-1:0] BEAT_MASK = WORD_W'((1 << NSHIFT) - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [WORD_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [WORD_W-1:0]  q_q [QUEUE_WORDS];
  logic [WORD_W-1:0]  q_d [QUEUE_WORDS];
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  inst_q, inst_d;
  logic               inst_valid_q, inst_valid_d;
  logic [WORD_W-1:0]  imm_q, imm_d;
  logic               imm16_loaded_q, imm16_loaded_d;
  logic [WORD_W-1:0]  pc_q, pc_d;

  logic               commit;
  logic               beat_last;
  logic               push;
  logic               nonempty;
  logic               imm_pop;
  logic               inst_pop;
  logic               pop;
  logic [WORD_W-1:0]  word_in;
  logic [WORD_W-1:0]  head;
  logic [CNT_W-1:0]   wr_idx;
  logic [SH_W-1:0]    pc_sh;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      beat_q         <= '0;
      sr_q           <= '0;
      fetch_addr_q   <= '0;
      cnt_q          <= '0;
      inst_q         <= '0;
      inst_valid_q   <= 1'b0;
      imm_q          <= '0;
      imm16_loaded_q <= 1'b0;
      pc_q           <= '0;
      for (int unsigned i = 0; i < QUEUE_WORDS; i++) q_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      sr_q           <= sr_d;
      fetch_addr_q   <= fetch_addr_d;
      cnt_q          <= cnt_d;
      inst_q         <= inst_d;
      inst_valid_q   <= inst_valid_d;
      imm_q          <= imm_d;
      imm16_loaded_q <= imm16_loaded_d;
      pc_q           <= pc_d;
      for (int unsigned i = 0; i < QUEUE_WORDS; i++) q_q[i] <= q_d[i];
    end
  end

  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    sr_d           = sr_q;
    fetch_addr_d   = fetch_addr_q;
    cnt_d          = cnt_q;
    inst_d         = inst_q;
    inst_valid_d   = inst_valid_q;
    imm_d          = imm_q;
    imm16_loaded_d = imm16_loaded_q;
    pc_d           = pc_q;
    for (int unsigned i = 0; i < QUEUE_WORDS; i++) q_d[i] = q_q[i];

    pc_sh     = SH_W'(comp_counter_i) * SH_W'(NSHIFT);
    commit    = write_pc_i && (comp_counter_i == 3'(WORD_BEATS - 1));
    beat_last = fetch_data_valid_i && (beat_q == BEAT_W'(WORD_BEATS - 1));
    word_in   = {fetch_data_i, sr_q};
    head      = q_q[0];
    push      = (state_q == ST_DATA) && beat_last && !commit;
    // A PC commit retargets the stream, so nothing is consumed in that cycle.
    nonempty  = (cnt_q != '0) && !commit;
    imm_pop   = load_imm16_i && !imm16_loaded_q && nonempty;
    inst_pop  = !inst_valid_q && nonempty && !imm_pop;
    pop       = imm_pop || inst_pop;
    wr_idx    = cnt_q - CNT_W'(pop);

    // Fetch sequencer; one outstanding fetch keeps a queue slot reserved.
    case (state_q)
      ST_IDLE: begin
        if (!block_prefetch_i && (cnt_q < CNT_W'(QUEUE_WORDS))) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (fetch_ack_i) begin
          state_d      = ST_DATA;
          beat_d       = '0;
          fetch_addr_d = fetch_addr_q + WORD_W'(2);
        end
      end
      ST_DATA: begin
        if (fetch_data_valid_i) begin
          beat_d = beat_q + BEAT_W'(1);
          sr_d   = word_in[WORD_W-1:NSHIFT];
        end
        if (beat_last) state_d = ST_IDLE;
        else if (commit) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (fetch_data_valid_i) beat_d = beat_q + BEAT_W'(1);
        if (beat_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit && (state_q == ST_REQ)) begin
      state_d = fetch_ack_i ? ST_DISCARD : ST_IDLE;
      beat_d  = '0;
    end

    if (inst_done_i) begin
      inst_valid_d   = 1'b0;
      imm16_loaded_d = 1'b0;
    end
    if (next_imm_data_i) imm_d = {imm_q[NSHIFT-1:0], imm_q[WORD_W-1:NSHIFT]};

    if (pop) begin
      for (int unsigned i = 0; i + 1 < QUEUE_WORDS; i++) q_d[i] = q_q[i+1];
      cnt_d = cnt_q - CNT_W'(1);
      pc_d  = pc_q + WORD_W'(2);
    end
    if (inst_pop) begin
      inst_d       = head;
      inst_valid_d = 1'b1;
      imm_d        = {{8{head[7]}}, head[7:0]};
    end
    if (imm_pop) begin
      imm_d          = head;
      imm16_loaded_d = 1'b1;
    end

    if (push) begin
      for (int unsigned i = 0; i < QUEUE_WORDS; i++) begin
        if (CNT_W'(i) == wr_idx) q_d[i] = word_in;
      end
      cnt_d = cnt_d + CNT_W'(1);
    end

    if (write_pc_i) pc_d = (pc_d & ~(BEAT_MASK << pc_sh)) | (WORD_W'(pc_data_out_i) << pc_sh);
    if (commit) begin
      cnt_d        = '0;
      fetch_addr_d = pc_d;
    end
  end

  assign fetch_req_o     = (state_q == ST_REQ);
  assign prefetch_idle_o = (state_q == ST_IDLE);
  assign fetch_addr_o    = fetch_addr_q;
  assign inst_valid_o    = inst_valid_q;
  assign inst_o          = inst_q;
  assign imm16_loaded_o  = imm16_loaded_q;
  assign imm_full_o      = imm_q;
  assign imm_data_in_o   = imm_q[NSHIFT-1:0];
  assign pc_data_in_o    = NSHIFT'(pc_q >> pc_sh);

endmodule
